// File: rtl/uart_echo_checker.sv
// Host-side UART echo checker. It sends a cycling character sequence as 8N1 serial,
// receives each echoed byte, and scores it against rot13 of the character that was sent.
module uart_echo_checker #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TIMEOUT_CLKS = 24000,
  parameter logic [7:0]  START_CHAR   = 8'h20,
  parameter logic [7:0]  END_CHAR     = 8'h7E
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic        tx,
  input  logic        rx,
  output logic        busy,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic [15:0] timeout_count,
  output logic [7:0]  last_sent,
  output logic [7:0]  last_received,
  output logic        error_flag
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CLKS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RECV  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_d;
  logic [3:0]       bit_idx, bit_idx_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d, tmo_inc;
  logic [7:0]       cur_char, cur_char_d, next_char;
  logic [7:0]       rx_shift, rx_shift_d;
  logic             stop_seen, stop_seen_d;
  logic             rx_meta, rx_sync, rx_prev;
  logic             tx_d, busy_d, error_flag_d;
  logic [15:0]      pass_count_d, fail_count_d, timeout_count_d;
  logic [7:0]       last_sent_d, last_received_d;

  function automatic logic [7:0] rot13(input logic [7:0] c);
    logic [7:0] r;
    r = c;
    if ((c >= 8'h41 && c <= 8'h4D) || (c >= 8'h61 && c <= 8'h6D)) r = c + 8'd13;
    else if ((c >= 8'h4E && c <= 8'h5A) || (c >= 8'h6E && c <= 8'h7A)) r = c - 8'd13;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign next_char = (cur_char == END_CHAR) ? START_CHAR : cur_char + 8'd1;
  // Timeout counter holds at the limit so a long RECV cannot wrap it
  assign tmo_inc   = (tmo_cnt < TMO_LIMIT) ? tmo_cnt + TMO_W'(1) : tmo_cnt;

  always_comb begin
    state_d         = state;
    clk_cnt_d       = clk_cnt;
    bit_idx_d       = bit_idx;
    tmo_cnt_d       = tmo_cnt;
    cur_char_d      = cur_char;
    rx_shift_d      = rx_shift;
    stop_seen_d     = stop_seen | stop;
    tx_d            = tx;
    busy_d          = busy;
    pass_count_d    = pass_count;
    fail_count_d    = fail_count;
    timeout_count_d = timeout_count;
    last_sent_d     = last_sent;
    last_received_d = last_received;
    error_flag_d    = error_flag;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d         = S_SEND;
          clk_cnt_d       = '0;
          bit_idx_d       = '0;
          tx_d            = 1'b0;
          busy_d          = 1'b1;
          pass_count_d    = '0;
          fail_count_d    = '0;
          timeout_count_d = '0;
          error_flag_d    = 1'b0;
          last_received_d = '0;
          cur_char_d      = START_CHAR;
          last_sent_d     = START_CHAR;
          stop_seen_d     = stop;
        end
      end

      // bit_idx is the bit currently on tx: 0 start, 1-8 data, 9 stop
      S_SEND: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx == 4'd9) begin
            state_d   = S_WAIT;
            tmo_cnt_d = '0;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 4'd1;
            tx_d      = (bit_idx == 4'd8) ? 1'b1 : last_sent[bit_idx[2:0]];
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end

      S_WAIT: begin
        tmo_cnt_d = tmo_inc;
        if (tmo_inc >= TMO_LIMIT) begin
          timeout_count_d = sat_inc(timeout_count);
          error_flag_d    = 1'b1;
          state_d         = S_GAP;
          clk_cnt_d       = '0;
        end else if (rx_prev && !rx_sync) begin
          state_d   = S_RECV;
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end
      end

      // bit_idx 0 is the mid-start recheck, 1-8 data, 9 stop
      S_RECV: begin
        tmo_cnt_d = tmo_inc;
        if (clk_cnt == ((bit_idx == 4'd0) ? HALF_LAST : BIT_LAST)) begin
          clk_cnt_d = '0;
          if (bit_idx == 4'd0) begin
            if (rx_sync) state_d = S_WAIT;
            else         bit_idx_d = 4'd1;
          end else if (bit_idx == 4'd9) begin
            last_received_d = rx_shift;
            if (rx_sync) begin
              state_d = S_CHECK;
            end else begin
              fail_count_d = sat_inc(fail_count);
              error_flag_d = 1'b1;
              state_d      = S_GAP;
            end
          end else begin
            rx_shift_d = {rx_sync, rx_shift[7:1]};
            bit_idx_d  = bit_idx + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (last_received == rot13(last_sent)) begin
          pass_count_d = sat_inc(pass_count);
        end else begin
          fail_count_d = sat_inc(fail_count);
          error_flag_d = 1'b1;
        end
        state_d   = S_GAP;
        clk_cnt_d = '0;
      end

      S_GAP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_d  = '0;
          cur_char_d = next_char;
          if (stop_seen || stop) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d     = S_SEND;
            bit_idx_d   = '0;
            tx_d        = 1'b0;
            last_sent_d = next_char;
            stop_seen_d = stop;
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      tmo_cnt       <= '0;
      cur_char      <= '0;
      rx_shift      <= '0;
      stop_seen     <= 1'b0;
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      tx            <= 1'b1;
      busy          <= 1'b0;
      pass_count    <= '0;
      fail_count    <= '0;
      timeout_count <= '0;
      last_sent     <= '0;
      last_received <= '0;
      error_flag    <= 1'b0;
    end else begin
      state         <= state_d;
      clk_cnt       <= clk_cnt_d;
      bit_idx       <= bit_idx_d;
      tmo_cnt       <= tmo_cnt_d;
      cur_char      <= cur_char_d;
      rx_shift      <= rx_shift_d;
      stop_seen     <= stop_seen_d;
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      tx            <= tx_d;
      busy          <= busy_d;
      pass_count    <= pass_count_d;
      fail_count    <= fail_count_d;
      timeout_count <= timeout_count_d;
      last_sent     <= last_sent_d;
      last_received <= last_received_d;
      error_flag    <= error_flag_d;
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: a serial monitor/echo model on tx->rx, a scoreboard of
// expected sent characters, table-driven runs, plus timeout and mid-frame reset sequences.
module tb_uart_echo_checker;

  localparam int unsigned CPB = 4;
  localparam int M_ROT     = 0;
  localparam int M_SAME    = 1;
  localparam int M_BADSTOP = 2;
  localparam int M_NONE    = 3;

  typedef struct {
    int          mode;
    int          nchars;
    logic [15:0] exp_pass;
    logic [15:0] exp_fail;
    logic [15:0] exp_tmo;
    logic [7:0]  exp_last_sent;
    logic [7:0]  exp_last_recv;
    logic        exp_err;
  } vec_t;

  logic        clock, reset, start, stop, tx, rx, busy, error_flag;
  logic [15:0] pass_count, fail_count, timeout_count;
  logic [7:0]  last_sent, last_received;

  int          checks = 0;
  int          errors = 0;
  int          frames = 0;
  int          echo_mode = 0;
  logic [7:0]  exp_q[$];

  uart_echo_checker #(
    .CLKS_PER_BIT(4), .TIMEOUT_CLKS(200), .START_CHAR(8'h41), .END_CHAR(8'h43)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .tx(tx), .rx(rx),
    .busy(busy), .pass_count(pass_count), .fail_count(fail_count),
    .timeout_count(timeout_count), .last_sent(last_sent),
    .last_received(last_received), .error_flag(error_flag)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] ref_rot13(input logic [7:0] c);
    int base;
    if (c >= 8'h41 && c <= 8'h5A)      base = 65;
    else if (c >= 8'h61 && c <= 8'h7A) base = 97;
    else return c;
    return 8'((int'(c) - base + 13) % 26 + base);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic good_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("busy_drop", 16'(busy), 16'd0);
  endtask

  task automatic wait_frames(input int target, input int limit);
    int n;
    n = 0;
    while (frames < target && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("frame_arrival", 16'(frames >= target), 16'd1);
  endtask

  // Decodes DUT frames mid-bit, scores them against the queue, then plays the echo device
  initial begin : monitor
    logic [7:0] data, exp_c;
    logic       bad, sb, stb;
    int         w;
    rx = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
          w = (k == 0) ? 2 : CPB;
          repeat (w) begin
            @(negedge clock);
            if (reset) bad = 1'b1;
          end
          if (k == 0)      sb = tx;
          else if (k == 9) stb = tx;
          else             data[k-1] = tx;
        end
        if (!bad) begin
          frames++;
          check("tx_start_bit", 16'(sb), 16'd0);
          check("tx_stop_bit", 16'(stb), 16'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h required=none", data);
          end else begin
            exp_c = exp_q.pop_front();
            check("sent_char", 16'(data), 16'(exp_c));
          end
          if (echo_mode != M_NONE) begin
            repeat (3) @(negedge clock);
            send_rx((echo_mode == M_SAME) ? data : ref_rot13(data), echo_mode != M_BADSTOP);
          end
        end
      end
    end
  end

  task automatic run_row(input vec_t v);
    logic [7:0] c;
    int         base;
    echo_mode = v.mode;
    c = 8'h41;
    for (int i = 0; i < v.nchars; i++) begin
      exp_q.push_back(c);
      c = (c == 8'h43) ? 8'h41 : c + 8'd1;
    end
    base  = frames;
    stop  = (v.nchars == 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 16'(busy), 16'd1);
    if (v.nchars > 1) begin
      wait_frames(base + v.nchars, 400 * v.nchars);
      stop = 1'b1;
    end
    wait_idle(400 * v.nchars + 400);
    stop = 1'b0;
    check("pass_count", pass_count, v.exp_pass);
    check("fail_count", fail_count, v.exp_fail);
    check("timeout_count", timeout_count, v.exp_tmo);
    check("last_sent", 16'(last_sent), 16'(v.exp_last_sent));
    check("last_received", 16'(last_received), 16'(v.exp_last_recv));
    check("error_flag", 16'(error_flag), 16'(v.exp_err));
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    repeat (10) @(negedge clock);
  endtask

  initial begin : main
    vec_t vecs[5];
    logic found;
    int   base;

    vecs[0] = '{M_ROT,     1, 16'd1, 16'd0, 16'd0, 8'h41, 8'h4E, 1'b0};
    vecs[1] = '{M_SAME,    1, 16'd0, 16'd1, 16'd0, 8'h41, 8'h41, 1'b1};
    vecs[2] = '{M_BADSTOP, 1, 16'd0, 16'd1, 16'd0, 8'h41, 8'h4E, 1'b1};
    vecs[3] = '{M_NONE,    2, 16'd0, 16'd0, 16'd2, 8'h42, 8'h00, 1'b1};
    vecs[4] = '{M_ROT,     4, 16'd4, 16'd0, 16'd0, 8'h41, 8'h4E, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", 16'(tx), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_pass", pass_count, 16'd0);
    check("rst_fail", fail_count, 16'd0);
    check("rst_timeout", timeout_count, 16'd0);
    check("rst_last_sent", 16'(last_sent), 16'd0);
    check("rst_last_received", 16'(last_received), 16'd0);
    check("rst_error_flag", 16'(error_flag), 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 5; i++) run_row(vecs[i]);

    // Exact timeout latency, then a start pulse mid-run that must be ignored
    echo_mode = M_NONE;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    base  = frames;
    stop  = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (tx === 1'b0) found = 1'b1;
      else @(negedge clock);
    end
    check("tmo_frame_begins", 16'(found), 16'd1);
    repeat (239) @(negedge clock);
    check("tmo_not_yet", timeout_count, 16'd0);
    @(negedge clock);
    check("tmo_at_200", timeout_count, 16'd1);
    check("tmo_error_flag", 16'(error_flag), 16'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("start_ignored_count", timeout_count, 16'd1);
    check("start_ignored_busy", 16'(busy), 16'd1);
    wait_frames(base + 2, 600);
    stop = 1'b1;
    wait_idle(800);
    stop = 1'b0;
    check("tmo_total", timeout_count, 16'd2);
    check("tmo_last_sent", 16'(last_sent), 16'h42);
    check("tmo_queue_drained", 16'(exp_q.size()), 16'd0);
    repeat (10) @(negedge clock);

    // Reset in the data bits of the second frame
    echo_mode = M_ROT;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    base  = frames;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_frames(base + 1, 400);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (tx === 1'b0) found = 1'b1;
      else @(negedge clock);
    end
    check("second_frame_begins", 16'(found), 16'd1);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_tx", 16'(tx), 16'd1);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_pass", pass_count, 16'd0);
    check("midrst_fail", fail_count, 16'd0);
    check("midrst_timeout", timeout_count, 16'd0);
    check("midrst_last_sent", 16'(last_sent), 16'd0);
    check("midrst_error_flag", 16'(error_flag), 16'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (60) @(negedge clock);
    exp_q.push_back(8'h41);
    stop  = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle(400);
    stop = 1'b0;
    check("post_rst_last_sent", 16'(last_sent), 16'h41);
    check("post_rst_pass", pass_count, 16'd1);
    check("post_rst_fail", fail_count, 16'd0);
    check("post_rst_queue_drained", 16'(exp_q.size()), 16'd0);

    repeat (10) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
